// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/redirect controller.
//   - Bus/index macros used across the pipeline (stall vector layout, stage
//     indices, controller state encodings, and a fallback address bus).
//   - Package with the controller state enum, per-request stall patterns and
//     a helper that derives the bubble vector from a stall vector.
// No ports; this file is compiled ahead of every file that imports it.
// ---------------------------------------------------------------------------
`ifndef PIPELINE_CTRL_DEFINES
`define PIPELINE_CTRL_DEFINES

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif

`define STALL_BUS  4:0
`define STAGE_IF   0
`define STAGE_ID   1
`define STAGE_EX   2
`define STAGE_MEM  3
`define STAGE_WB   4

`define PCTRL_RUN  1'b0
`define PCTRL_HOLD 1'b1

`endif

package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN  = `PCTRL_RUN,
      HOLD = `PCTRL_HOLD
   } pctrl_state_t;

   // A stall request freezes its own stage and everything upstream of it.
   localparam logic [`STALL_BUS] STALL_PAT_MEM  = 5'b01111;
   localparam logic [`STALL_BUS] STALL_PAT_EX   = 5'b00111;
   localparam logic [`STALL_BUS] STALL_PAT_ID   = 5'b00011;
   localparam logic [`STALL_BUS] STALL_PAT_IF   = 5'b00001;
   localparam logic [`STALL_BUS] STALL_PAT_NONE = 5'b00000;

   // A bubble goes in at the boundary where a held stage feeds a stage that
   // keeps moving; WB has nothing downstream so its bit is always 0.
   function automatic logic [`STALL_BUS] bubble_of(input logic [`STALL_BUS] s);
      return {1'b0, s[`STAGE_MEM:`STAGE_IF] & ~s[`STAGE_WB:`STAGE_ID]};
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_prio.sv
// ---------------------------------------------------------------------------
// pipeline_stall_prio
// Combinational priority encode of the four per-stage stall requests into a
// single stall vector plus the matching bubble-insert vector.
// Ports:
//   stall_req_if/id/ex/mem  in   per-stage stall requests
//   stall                   out  1 = hold stage ([0]=PC/IF .. [4]=WB)
//   bubble                  out  1 = pipe reg into stage i+1 loads a NOP
// ---------------------------------------------------------------------------
module pipeline_stall_prio
   import pipeline_ctrl_pkg::*;
(
   input  logic              stall_req_if,
   input  logic              stall_req_id,
   input  logic              stall_req_ex,
   input  logic              stall_req_mem,
   output logic [`STALL_BUS] stall,
   output logic [`STALL_BUS] bubble
);

   // The furthest-downstream request wins since it already covers every
   // stage upstream of it.
   always_comb begin
      stall = STALL_PAT_NONE;
      if (stall_req_mem)
         stall = STALL_PAT_MEM;
      else if (stall_req_ex)
         stall = STALL_PAT_EX;
      else if (stall_req_id)
         stall = STALL_PAT_ID;
      else if (stall_req_if)
         stall = STALL_PAT_IF;
      bubble = bubble_of(stall);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/bubble sequencer for the 5-stage pipeline. Merges stall
// requests, derives bubbles, sequences PC redirects for branches resolved in
// ID (deferring them while IF is waiting on a fetch) and flags runaway stalls.
// Parameters:
//   STALL_TIMEOUT  consecutive stalled cycles before stall_timeout sets
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   stall_req_*          per-stage stall requests (if/id/ex/mem)
//   branch_flag          ID resolved a taken branch this cycle
//   branch_addr          branch target from ID
//   stall, bubble        combined stall and NOP-insert vectors
//   pc_redirect          PC loads pc_target this edge
//   pc_target            redirect address, 0 when not redirecting
//   stall_timeout        sticky runaway-stall flag, cleared only by rst
// ---------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int STALL_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_req_if,
   input  logic              stall_req_id,
   input  logic              stall_req_ex,
   input  logic              stall_req_mem,
   input  logic              branch_flag,
   input  logic [`ADDR_BUS]  branch_addr,
   output logic [`STALL_BUS] stall,
   output logic [`STALL_BUS] bubble,
   output logic              pc_redirect,
   output logic [`ADDR_BUS]  pc_target,
   output logic              stall_timeout
);

   localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

   logic [`STALL_BUS] raw_stall;
   logic [`STALL_BUS] raw_bubble;
   pctrl_state_t      state;
   pctrl_state_t      next_state;
   logic [`ADDR_BUS]  pend_addr;
   logic              pend_load;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  cnt_next;

   pipeline_stall_prio u_prio (
      .stall_req_if  (stall_req_if),
      .stall_req_id  (stall_req_id),
      .stall_req_ex  (stall_req_ex),
      .stall_req_mem (stall_req_mem),
      .stall         (raw_stall),
      .bubble        (raw_bubble)
   );

   // Reset forces the pipeline controls quiet so nothing is held or flushed
   // while the rest of the core is being initialised.
   always_comb begin
      stall  = rst ? '0 : raw_stall;
      bubble = rst ? '0 : raw_bubble;
   end

   // Redirect sequencing. A branch seen while ID itself is held is ignored
   // because it will be presented again. A branch seen while only IF is held
   // (delay slot still fetching) is parked in pend_addr and issued on the
   // first cycle IF is free again.
   always_comb begin
      next_state  = state;
      pc_redirect = 1'b0;
      pc_target   = '0;
      pend_load   = 1'b0;
      if (!rst) begin
         unique case (state)
            RUN: begin
               if (branch_flag && !stall[`STAGE_ID]) begin
                  if (!stall[`STAGE_IF]) begin
                     pc_redirect = 1'b1;
                     pc_target   = branch_addr;
                  end else begin
                     pend_load  = 1'b1;
                     next_state = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall[`STAGE_IF]) begin
                  pc_redirect = 1'b1;
                  pc_target   = pend_addr;
                  next_state  = RUN;
               end
            end
            default: next_state = RUN;
         endcase
      end
   end

   // Consecutive-stall counter: restarts on any free cycle and parks at the
   // limit so it cannot wrap during a very long stall.
   always_comb begin
      cnt_next = '0;
      if (stall != '0)
         cnt_next = (stall_cnt == CNT_MAX) ? CNT_MAX : stall_cnt + CNT_W'(1);
   end

   // State, pending target, stall counter and sticky timeout flag. The flag
   // sets on the edge that completes the limit-th stalled cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         pend_addr     <= '0;
         stall_cnt     <= '0;
         stall_timeout <= 1'b0;
      end else begin
         state     <= next_state;
         stall_cnt <= cnt_next;
         if (pend_load)
            pend_addr <= branch_addr;
         if (cnt_next == CNT_MAX)
            stall_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: a table of single-cycle vectors for
// the combinational stall/bubble/redirect paths, plus hand-written sequences
// for reset, deferred redirects and the stall timeout.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   logic              clk;
   logic              rst;
   logic              stall_req_if;
   logic              stall_req_id;
   logic              stall_req_ex;
   logic              stall_req_mem;
   logic              branch_flag;
   logic [`ADDR_BUS]  branch_addr;
   logic [`STALL_BUS] stall;
   logic [`STALL_BUS] bubble;
   logic              pc_redirect;
   logic [`ADDR_BUS]  pc_target;
   logic              stall_timeout;

   int tests_run  = 0;
   int fail_count = 0;

   typedef struct {
      logic [3:0]  reqs;
      logic        br;
      logic [31:0] addr;
      logic [4:0]  exp_stall;
      logic [4:0]  exp_bubble;
      logic        exp_redir;
      logic [31:0] exp_target;
   } vec_t;

   vec_t vecs[12];

   pipeline_ctrl #(.STALL_TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_req_if  (stall_req_if),
      .stall_req_id  (stall_req_id),
      .stall_req_ex  (stall_req_ex),
      .stall_req_mem (stall_req_mem),
      .branch_flag   (branch_flag),
      .branch_addr   (branch_addr),
      .stall         (stall),
      .bubble        (bubble),
      .pc_redirect   (pc_redirect),
      .pc_target     (pc_target),
      .stall_timeout (stall_timeout)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A branch while a redirect is parked must never be presented by ID.
   always @(negedge clk) begin
      #2;
      if (!rst && dut.state == HOLD && branch_flag) begin
         fail_count++;
         $display("[TB] FAIL hold_branch: branch_flag=1 seen while HOLD, required none");
      end
   end

   // Drive the request bits {mem,ex,id,if} and the branch inputs.
   task automatic applyStimulus(input logic [3:0] reqs, input logic br,
                                input logic [31:0] addr);
      stall_req_mem = reqs[3];
      stall_req_ex  = reqs[2];
      stall_req_id  = reqs[1];
      stall_req_if  = reqs[0];
      branch_flag   = br;
      branch_addr   = addr;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Move to the next cycle: inputs change at negedge, checks land 1 ns later.
   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic doReset();
      nextCycle();
      rst = 1'b1;
      applyStimulus(4'b0000, 1'b0, 32'h0);
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{4'b0000, 1'b0, 32'h0,         5'b00000, 5'b00000, 1'b0, 32'h0};
      vecs[1]  = '{4'b0001, 1'b0, 32'h0,         5'b00001, 5'b00001, 1'b0, 32'h0};
      vecs[2]  = '{4'b0010, 1'b0, 32'h0,         5'b00011, 5'b00010, 1'b0, 32'h0};
      vecs[3]  = '{4'b0100, 1'b0, 32'h0,         5'b00111, 5'b00100, 1'b0, 32'h0};
      vecs[4]  = '{4'b1000, 1'b0, 32'h0,         5'b01111, 5'b01000, 1'b0, 32'h0};
      vecs[5]  = '{4'b1010, 1'b0, 32'h0,         5'b01111, 5'b01000, 1'b0, 32'h0};
      vecs[6]  = '{4'b0011, 1'b0, 32'h0,         5'b00011, 5'b00010, 1'b0, 32'h0};
      vecs[7]  = '{4'b1111, 1'b0, 32'h0,         5'b01111, 5'b01000, 1'b0, 32'h0};
      vecs[8]  = '{4'b0000, 1'b1, 32'h0040_0100, 5'b00000, 5'b00000, 1'b1, 32'h0040_0100};
      vecs[9]  = '{4'b0010, 1'b1, 32'h0040_0300, 5'b00011, 5'b00010, 1'b0, 32'h0};
      vecs[10] = '{4'b0110, 1'b1, 32'h0040_0400, 5'b00111, 5'b00100, 1'b0, 32'h0};
      vecs[11] = '{4'b1000, 1'b1, 32'h0040_0500, 5'b01111, 5'b01000, 1'b0, 32'h0};

      rst = 1'b1;
      applyStimulus(4'b1111, 1'b1, 32'hDEAD_BEEF);

      // Reset holds every output quiet even with all requests asserted.
      nextCycle();
      nextCycle();
      #1;
      checkOutput("rst_stall",    32'(stall),         32'h0);
      checkOutput("rst_bubble",   32'(bubble),        32'h0);
      checkOutput("rst_redirect", 32'(pc_redirect),   32'h0);
      checkOutput("rst_target",   pc_target,          32'h0);
      checkOutput("rst_timeout",  32'(stall_timeout), 32'h0);

      nextCycle();
      rst = 1'b0;
      applyStimulus(4'b0000, 1'b0, 32'h0);
      #1;
      checkOutput("idle_stall",    32'(stall),       32'h0);
      checkOutput("idle_redirect", 32'(pc_redirect), 32'h0);

      // Table vectors; none of them parks a redirect, so the FSM stays in RUN.
      for (int i = 0; i < 12; i++) begin
         nextCycle();
         applyStimulus(vecs[i].reqs, vecs[i].br, vecs[i].addr);
         #1;
         checkOutput($sformatf("vec%0d_stall", i),    32'(stall),       32'(vecs[i].exp_stall));
         checkOutput($sformatf("vec%0d_bubble", i),   32'(bubble),      32'(vecs[i].exp_bubble));
         checkOutput($sformatf("vec%0d_redirect", i), 32'(pc_redirect), 32'(vecs[i].exp_redir));
         checkOutput($sformatf("vec%0d_target", i),   pc_target,        vecs[i].exp_target);
      end

      // Branch during an IF-only wait is deferred until IF frees up.
      doReset();
      applyStimulus(4'b0001, 1'b1, 32'h0040_0200);
      #1;
      checkOutput("defer_c1_redirect", 32'(pc_redirect), 32'h0);
      for (int c = 2; c <= 3; c++) begin
         nextCycle();
         applyStimulus(4'b0001, 1'b0, 32'h0);
         #1;
         checkOutput($sformatf("defer_c%0d_redirect", c), 32'(pc_redirect), 32'h0);
      end
      nextCycle();
      applyStimulus(4'b0000, 1'b0, 32'h0);
      #1;
      checkOutput("defer_c4_redirect", 32'(pc_redirect), 32'h1);
      checkOutput("defer_c4_target",   pc_target,        32'h0040_0200);
      nextCycle();
      #1;
      checkOutput("defer_c5_redirect", 32'(pc_redirect), 32'h0);
      checkOutput("defer_c5_target",   pc_target,        32'h0);

      // Same sequence, but reset lands while the redirect is parked.
      doReset();
      applyStimulus(4'b0001, 1'b1, 32'h0040_0200);
      #1;
      checkOutput("drop_c1_redirect", 32'(pc_redirect), 32'h0);
      nextCycle();
      rst = 1'b1;
      applyStimulus(4'b0001, 1'b0, 32'h0);
      #1;
      checkOutput("drop_c2_redirect", 32'(pc_redirect), 32'h0);
      checkOutput("drop_c2_stall",    32'(stall),       32'h0);
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("drop_c3_redirect", 32'(pc_redirect), 32'h0);
      for (int c = 4; c <= 5; c++) begin
         nextCycle();
         applyStimulus(4'b0000, 1'b0, 32'h0);
         #1;
         checkOutput($sformatf("drop_c%0d_redirect", c), 32'(pc_redirect), 32'h0);
         checkOutput($sformatf("drop_c%0d_target", c),   pc_target,        32'h0);
      end

      // Runaway stall: limit of 4 consecutive stalled cycles.
      doReset();
      #1;
      checkOutput("to_start", 32'(stall_timeout), 32'h0);
      applyStimulus(4'b0100, 1'b0, 32'h0);
      for (int c = 1; c <= 6; c++) begin
         nextCycle();
         #1;
         checkOutput($sformatf("to_after_%0d", c), 32'(stall_timeout),
                     (c >= 4) ? 32'h1 : 32'h0);
      end
      applyStimulus(4'b0000, 1'b0, 32'h0);
      nextCycle();
      nextCycle();
      #1;
      checkOutput("to_sticky", 32'(stall_timeout), 32'h1);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("to_cleared", 32'(stall_timeout), 32'h0);

      // A 3-cycle stall burst stays under the limit.
      applyStimulus(4'b0010, 1'b0, 32'h0);
      for (int c = 0; c < 3; c++) nextCycle();
      applyStimulus(4'b0000, 1'b0, 32'h0);
      nextCycle();
      #1;
      checkOutput("to_short_burst", 32'(stall_timeout), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
